decode_issue_stage: RTL and testbench
=====================================

# decode_issue_stage

Single-entry decode/issue stage of the in-order RISC-V pipeline, sitting between fetch and execute and directly driving the register-file read ports and scoreboard. It:
- accepts one instruction at a time from fetch over a valid/ready handshake;
- decodes register usage and the immediate;
- stalls while a source or destination register is still pending writeback;
- captures operands, marks the destination as pending, and presents a decoded packet to execute.

## Interface
Parameters:
- XLEN, 32, datapath width
- NREG, 32, architectural register count; index width is 5 bits

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discards an instruction not yet issued
- in_valid  in  1  fetch packet valid
- in_ready  out  1  stage can accept a fetch packet
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address
- reada, readb  out  1  source-use flags to the register file
- ra, rb  out  5  rs1/rs2 indices to the register file
- busa, busb  in  32  register-file read data, combinational
- conflict  in  1  register-file scoreboard hit on a used source
- protect  out  1  one-cycle pulse: mark protectw pending
- protectw  out  5  destination index being marked
- wb_we  in  1  writeback write enable, the same signal the register file sees
- wb_rw  in  5  writeback index
- wb_busw  in  32  writeback data; used only with WB_FORWARD_EN
- out_valid  out  1  decoded packet valid
- out_ready  in  1  execute accepts the packet
- out_pc, out_instr  out  32  issued instruction
- out_rs1_val, out_rs2_val  out  32  operand values
- out_imm  out  32  sign-extended immediate
- out_rd  out  5  destination index
- out_rd_we  out  1  instruction writes rd, and rd != 0

## Operation
Decode by opcode:
- 0110011 (R-type): reads rs1 and rs2; writes rd.
- 0010011, 0000011, 1100111 (I-type ALU, load, JALR): reads rs1 only; writes rd; I-type immediate.
- 0100011 (store): reads rs1 and rs2; no rd; S-type immediate.
- 1100011 (branch): reads rs1 and rs2; no rd; B-type immediate.
- 0110111, 0010111 (LUI, AUIPC): no sources; writes rd; U-type immediate.
- 1101111 (JAL): no sources; writes rd; J-type immediate.
- Any other opcode: issued as a NOP (no reads, out_rd_we=0, out_imm=0).

Pending mask (32 bits, local mirror of the register-file scoreboard):
- Bit set on a protect pulse.
- Bit cleared on wb_we with wb_rw != 0.
- When both hit the same index in one cycle, set wins.
- Bit 0 is never set.

State machine:
- IDLE: in_ready=1. On in_valid, latch instr and pc; go to WAIT.
- WAIT: drive ra, rb, reada, readb from the latched instruction.
  - Hazard = (source stall, see Configuration) OR (out_rd_we AND mask[rd] AND NOT (wb_we AND wb_rw==rd)).
  - No hazard: capture operands and immediate into the output register, pulse protect (when out_rd_we) with protectw=rd, go to SEND.
  - Hazard: stay in WAIT.
- SEND: out_valid=1. On out_ready, go to IDLE. If in_valid is also high that cycle, in_ready=1 and the new packet is latched directly into WAIT.
- flush in IDLE or WAIT: go to IDLE, no protect pulse, latched instruction dropped. The flush has priority over issue in the same cycle.
- flush in SEND: ignored. The packet is already protected and must reach execute.

## Timing
- Reset values: state IDLE; mask all zero; every output 0 except in_ready=1.
- Minimum latency: accept at edge N, issue at edge N+1, out_valid high in cycle N+1.
- Throughput with back-to-back out_ready: 1 instruction per 2 cycles.
- protect is asserted combinationally in the issuing WAIT cycle. The register file sets the status bit at that same edge, so the next instruction's WAIT cycle sees it.
- Output register holds stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation: immediate return to reset values; in-flight instruction lost.

## Configuration
- WB_FORWARD_EN defined:
  - A source is stalled when it is used and its mask bit is set, unless wb_we && wb_rw==rs.
  - A source matching the writeback that cycle takes wb_busw instead of busa/busb and issues in that cycle.
  - The conflict input is unused.
- WB_FORWARD_EN undefined:
  - Source stall = conflict.
  - A source released by a writeback issues one cycle after the write edge, reading the updated register file.

## Test plan
- Reset, then addi x5,x0,7 (0x00700293), out_ready=1 -> out_valid one cycle after accept; out_rd=5, out_imm=7, out_rd_we=1; protect pulse with protectw=5; mask[5]=1.
- add x6,x5,x5 while x5 is pending, writeback wb_we=1 wb_rw=5 wb_busw=0x11 issued three cycles later:
  - Without macro: issues the cycle after the write, out_rs1_val=out_rs2_val=0x11.
  - With WB_FORWARD_EN: issues in the write cycle with the same values.
- Two writes to x7 back-to-back -> second stalls in WAIT until the first's writeback; exactly two protect pulses.
- sw x5,4(x2) -> readb=1, out_rd_we=0, out_imm=4, no protect pulse.
- flush asserted in WAIT while stalled on a conflict -> returns to IDLE, no protect pulse, out_valid stays 0.
- flush asserted in SEND -> ignored; packet still delivered.
- out_ready held low for 5 cycles in SEND -> outputs stable; in_ready=0 for all 5 cycles.

Source files
------------

// File: rtl/decode_issue_stage.sv
// decode_issue_stage: single-entry decode/issue stage between fetch and execute.
//
// Takes one instruction at a time from fetch (in_valid/in_ready). It decodes register usage
// and the immediate, and drives the register-file read ports (reada/readb, ra/rb). While a
// source or the destination is still pending writeback, it holds the instruction. Once the
// instruction can go, it captures operands, pulses protect/protectw to mark rd pending, and
// presents the packet to execute (out_valid/out_ready).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop an instruction that has not yet issued (IDLE/WAIT only)
//   in_valid/in_ready     fetch handshake; in_instr, in_pc carry the instruction
//   reada/readb, ra/rb    register-file read requests
//   busa/busb             register-file read data (combinational)
//   conflict              register-file scoreboard hit on a used source
//   protect/protectw      one-cycle pulse marking protectw pending
//   wb_we/wb_rw/wb_busw   writeback port as seen by the register file
//   out_valid/out_ready   execute handshake; out_* hold the issued packet
//
// Optional feature: define WB_FORWARD_EN to resolve source hazards from the local pending
// mask, forwarding wb_busw in the writeback cycle instead of waiting on conflict.
module decode_issue_stage #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            reada,
  output logic            readb,
  output logic [4:0]      ra,
  output logic [4:0]      rb,
  input  logic [XLEN-1:0] busa,
  input  logic [XLEN-1:0] busb,
  input  logic            conflict,
  output logic            protect,
  output logic [4:0]      protectw,
  input  logic            wb_we,
  input  logic [4:0]      wb_rw,
  input  logic [XLEN-1:0] wb_busw,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_rs1_val,
  output logic [XLEN-1:0] out_rs2_val,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_rd_we
);

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e            r_state, w_state_d;
  logic [31:0]       r_instr;
  logic [XLEN-1:0]   r_pc;
  logic [NREG-1:0]   r_pend_mask, w_mask_d;

  logic [6:0]        w_opcode;
  logic [4:0]        w_rs1, w_rs2, w_rd;
  logic              w_use1, w_use2, w_wr, w_rd_we;
  logic [31:0]       w_imm32;
  logic [XLEN-1:0]   w_imm;
  logic              w_src_stall, w_hazard;
  logic [XLEN-1:0]   w_opa, w_opb;
  logic              w_latch, w_issue;

  // Decode of the latched instruction.
  assign w_opcode = r_instr[6:0];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_rd     = r_instr[11:7];

  always_comb begin
    w_use1  = 1'b0;
    w_use2  = 1'b0;
    w_wr    = 1'b0;
    w_imm32 = '0;
    case (w_opcode)
      7'b0110011: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        w_wr   = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w_use1  = 1'b1;
        w_wr    = 1'b1;
        w_imm32 = {{20{r_instr[31]}}, r_instr[31:20]};
      end
      7'b0100011: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_imm32 = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      end
      7'b1100011: begin
        w_use1  = 1'b1;
        w_use2  = 1'b1;
        w_imm32 = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25],
                   r_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        w_wr    = 1'b1;
        w_imm32 = {r_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        w_wr    = 1'b1;
        w_imm32 = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20],
                   r_instr[30:21], 1'b0};
      end
      default: ;  // unknown opcode issues as a NOP
    endcase
  end

  assign w_rd_we = w_wr && (w_rd != 5'd0);
  assign w_imm   = XLEN'($signed(w_imm32));

`ifdef WB_FORWARD_EN
  logic w_fwd_a, w_fwd_b;
  logic unused_conflict;

  assign w_fwd_a = wb_we && (wb_rw == w_rs1) && (w_rs1 != 5'd0);
  assign w_fwd_b = wb_we && (wb_rw == w_rs2) && (w_rs2 != 5'd0);
  assign w_src_stall = (w_use1 && r_pend_mask[w_rs1] && !w_fwd_a) ||
                       (w_use2 && r_pend_mask[w_rs2] && !w_fwd_b);
  assign w_opa = w_fwd_a ? wb_busw : busa;
  assign w_opb = w_fwd_b ? wb_busw : busb;
  assign unused_conflict = conflict;
`else
  logic unused_wb_busw;

  // The register file's scoreboard decides; a released source is read the cycle after the
  // write edge, when busa/busb already carry the new value.
  assign w_src_stall = conflict;
  assign w_opa = busa;
  assign w_opb = busb;
  assign unused_wb_busw = ^wb_busw;
`endif

  // A writeback to rd in this cycle retires the older writer, so WAW need not wait for it.
  assign w_hazard = w_src_stall ||
                    (w_rd_we && r_pend_mask[w_rd] && !(wb_we && (wb_rw == w_rd)));

  always_comb begin
    w_state_d = r_state;
    in_ready  = 1'b0;
    reada     = 1'b0;
    readb     = 1'b0;
    ra        = '0;
    rb        = '0;
    protect   = 1'b0;
    protectw  = '0;
    w_latch   = 1'b0;
    w_issue   = 1'b0;
    case (r_state)
      StIdle: begin
        in_ready = 1'b1;
        if (!flush && in_valid) begin
          w_latch   = 1'b1;
          w_state_d = StWait;
        end
      end
      StWait: begin
        reada = w_use1;
        readb = w_use2;
        ra    = w_rs1;
        rb    = w_rs2;
        if (flush) begin
          w_state_d = StIdle;
        end else if (!w_hazard) begin
          w_issue   = 1'b1;
          protect   = w_rd_we;
          protectw  = w_rd_we ? w_rd : 5'd0;
          w_state_d = StSend;
        end
      end
      StSend: begin
        // flush is ignored here: rd is already protected, so the packet must reach execute.
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_latch   = 1'b1;
            w_state_d = StWait;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign out_valid = (r_state == StSend);

  // Local mirror of the scoreboard; a set in the same cycle as a clear wins.
  always_comb begin
    w_mask_d = r_pend_mask;
    if (wb_we && (wb_rw != 5'd0)) w_mask_d[wb_rw] = 1'b0;
    if (protect) w_mask_d[protectw] = 1'b1;
    w_mask_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_instr     <= '0;
      r_pc        <= '0;
      r_pend_mask <= '0;
      out_pc      <= '0;
      out_instr   <= '0;
      out_rs1_val <= '0;
      out_rs2_val <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pend_mask <= w_mask_d;
      if (w_latch) begin
        r_instr <= in_instr;
        r_pc    <= in_pc;
      end
      if (w_issue) begin
        out_pc      <= r_pc;
        out_instr   <= r_instr;
        out_rs1_val <= w_use1 ? w_opa : '0;
        out_rs2_val <= w_use2 ? w_opb : '0;
        out_imm     <= w_imm;
        out_rd      <= w_wr ? w_rd : 5'd0;
        out_rd_we   <= w_rd_we;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed bench for decode_issue_stage.
// Includes a small register file with its own scoreboard. It drives busa/busb and conflict,
// and applies protect pulses and writebacks the way the real register file does.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        reada, readb;
  logic [4:0]  ra, rb;
  logic [31:0] busa, busb;
  logic        conflict;
  logic        protect;
  logic [4:0]  protectw;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rw = '0;
  logic [31:0] wb_busw = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc, out_instr, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;

  int n_checks = 0;
  int n_errors = 0;
  int n_protect;
  int p0;

  decode_issue_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .reada(reada), .readb(readb), .ra(ra), .rb(rb), .busa(busa), .busb(busb),
    .conflict(conflict), .protect(protect), .protectw(protectw),
    .wb_we(wb_we), .wb_rw(wb_rw), .wb_busw(wb_busw),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_we(out_rd_we)
  );

  always #5 clk = ~clk;

  // Register file: x[i] resets to i*16; status bit set by protect, cleared by writeback.
  logic [31:0] rf [32];
  logic [31:0] sb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i) << 4;
    end else begin
      if (wb_we && wb_rw != 5'd0) begin
        rf[wb_rw] <= wb_busw;
        sb[wb_rw] <= 1'b0;
      end
      if (protect && protectw != 5'd0) sb[protectw] <= 1'b1;
    end
  end

  assign busa     = rf[ra];
  assign busb     = rf[rb];
  assign conflict = (reada && sb[ra]) || (readb && sb[rb]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_protect <= 0;
    else if (protect) n_protect <= n_protect + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    // Reset values
    mid();
    check_eq("rst_in_ready", 32'(in_ready), 1);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_protect", 32'(protect), 0);
    check_eq("rst_reada", 32'(reada), 0);
    check_eq("rst_out_imm", out_imm, 0);
    check_eq("rst_mask", dut.r_pend_mask, 0);
    next_cyc();
    rst_n = 1'b1;

    // addi x5,x0,7: one-cycle latency, protect x5
    next_cyc();
    offer(32'h00700293, 32'h1000);
    mid();
    check_eq("t1_in_ready", 32'(in_ready), 1);
    next_cyc();
    in_valid = 1'b0;
    mid();
    check_eq("t1_protect", 32'(protect), 1);
    check_eq("t1_protectw", 32'(protectw), 5);
    check_eq("t1_reada", 32'(reada), 1);
    check_eq("t1_valid_early", 32'(out_valid), 0);
    next_cyc();
    mid();
    check_eq("t1_out_valid", 32'(out_valid), 1);
    check_eq("t1_out_rd", 32'(out_rd), 5);
    check_eq("t1_out_imm", out_imm, 7);
    check_eq("t1_out_rd_we", 32'(out_rd_we), 1);
    check_eq("t1_out_pc", out_pc, 32'h1000);
    check_eq("t1_out_instr", out_instr, 32'h00700293);
    check_eq("t1_mask5", 32'(dut.r_pend_mask[5]), 1);
    next_cyc();
    mid();
    check_eq("t1_idle_valid", 32'(out_valid), 0);

    // add x6,x5,x5 with x5 pending; writeback of 0x11 in the third WAIT cycle
    next_cyc();
    offer(32'h00528333, 32'h1004);
    mid();
    next_cyc();
    in_valid = 1'b0;
    mid();
    check_eq("t2_stall1_protect", 32'(protect), 0);
    check_eq("t2_ra", 32'(ra), 5);
    next_cyc();
    mid();
    check_eq("t2_stall2_protect", 32'(protect), 0);
    next_cyc();
    wb_we = 1'b1;
    wb_rw = 5'd5;
    wb_busw = 32'h11;
    mid();
`ifdef WB_FORWARD_EN
    check_eq("t2_fwd_protect", 32'(protect), 1);
    check_eq("t2_fwd_protectw", 32'(protectw), 6);
    next_cyc();
    wb_we = 1'b0;
`else
    check_eq("t2_wbcycle_protect", 32'(protect), 0);
    next_cyc();
    wb_we = 1'b0;
    mid();
    check_eq("t2_after_wb_protect", 32'(protect), 1);
    check_eq("t2_after_wb_protectw", 32'(protectw), 6);
    next_cyc();
`endif
    mid();
    check_eq("t2_out_valid", 32'(out_valid), 1);
    check_eq("t2_rs1", out_rs1_val, 32'h11);
    check_eq("t2_rs2", out_rs2_val, 32'h11);
    check_eq("t2_out_rd", 32'(out_rd), 6);
    check_eq("t2_mask5", 32'(dut.r_pend_mask[5]), 0);
    check_eq("t2_mask6", 32'(dut.r_pend_mask[6]), 1);

    // Two writes to x7 back to back: second waits for the first's writeback
    next_cyc();
    p0 = n_protect;
    offer(32'h00100393, 32'h1008);
    mid();
    next_cyc();
    offer(32'h00200393, 32'h100c);
    mid();
    check_eq("t3_a_protect", 32'(protect), 1);
    check_eq("t3_a_protectw", 32'(protectw), 7);
    check_eq("t3_wait_in_ready", 32'(in_ready), 0);
    next_cyc();
    mid();
    check_eq("t3_a_valid", 32'(out_valid), 1);
    check_eq("t3_a_imm", out_imm, 1);
    check_eq("t3_send_in_ready", 32'(in_ready), 1);
    next_cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mid();
      check_eq("t3_b_stall_protect", 32'(protect), 0);
      check_eq("t3_b_stall_valid", 32'(out_valid), 0);
      next_cyc();
    end
    wb_we = 1'b1;
    wb_rw = 5'd7;
    wb_busw = 32'h1;
    mid();
    check_eq("t3_b_protect", 32'(protect), 1);
    check_eq("t3_b_protectw", 32'(protectw), 7);
    next_cyc();
    wb_we = 1'b0;
    mid();
    check_eq("t3_b_valid", 32'(out_valid), 1);
    check_eq("t3_b_imm", out_imm, 2);
    check_eq("t3_b_pc", out_pc, 32'h100c);
    check_eq("t3_mask7_set_wins", 32'(dut.r_pend_mask[7]), 1);
    check_eq("t3_protect_count", 32'(n_protect - p0), 2);

    // sw x5,4(x2)
    next_cyc();
    p0 = n_protect;
    offer(32'h00512223, 32'h1010);
    mid();
    next_cyc();
    in_valid = 1'b0;
    mid();
    check_eq("t4_reada", 32'(reada), 1);
    check_eq("t4_readb", 32'(readb), 1);
    check_eq("t4_ra", 32'(ra), 2);
    check_eq("t4_rb", 32'(rb), 5);
    check_eq("t4_protect", 32'(protect), 0);
    next_cyc();
    mid();
    check_eq("t4_valid", 32'(out_valid), 1);
    check_eq("t4_rd_we", 32'(out_rd_we), 0);
    check_eq("t4_imm", out_imm, 4);
    check_eq("t4_rs1", out_rs1_val, 32'h20);
    check_eq("t4_rs2", out_rs2_val, 32'h11);
    check_eq("t4_protect_count", 32'(n_protect - p0), 0);

    // add x8,x7,x7 stalled on pending x7, then flushed
    next_cyc();
    p0 = n_protect;
    offer(32'h00738433, 32'h1014);
    mid();
    next_cyc();
    in_valid = 1'b0;
    mid();
    check_eq("t5_stall_protect", 32'(protect), 0);
    next_cyc();
    flush = 1'b1;
    mid();
    check_eq("t5_flush_protect", 32'(protect), 0);
    next_cyc();
    flush = 1'b0;
    mid();
    check_eq("t5_idle_in_ready", 32'(in_ready), 1);
    check_eq("t5_idle_reada", 32'(reada), 0);
    check_eq("t5_valid", 32'(out_valid), 0);
    next_cyc();
    mid();
    check_eq("t5_valid_later", 32'(out_valid), 0);
    check_eq("t5_protect_count", 32'(n_protect - p0), 0);
    next_cyc();
    wb_we = 1'b1;
    wb_rw = 5'd7;
    wb_busw = 32'h77;
    mid();
    next_cyc();
    wb_we = 1'b0;

    // flush beats issue: addi x9 has no hazard but is flushed in WAIT
    offer(32'h00900493, 32'h1018);
    mid();
    next_cyc();
    in_valid = 1'b0;
    flush = 1'b1;
    mid();
    check_eq("t5b_flush_prio_protect", 32'(protect), 0);
    next_cyc();
    flush = 1'b0;
    mid();
    check_eq("t5b_valid", 32'(out_valid), 0);
    check_eq("t5b_mask9", 32'(dut.r_pend_mask[9]), 0);

    // addi x9 held in SEND for 5 cycles with out_ready low; flush in SEND ignored
    out_ready = 1'b0;
    next_cyc();
    offer(32'h00900493, 32'h101c);
    mid();
    next_cyc();
    offer(32'h12345537, 32'h1020);
    mid();
    check_eq("t6_protect", 32'(protect), 1);
    check_eq("t6_protectw", 32'(protectw), 9);
    next_cyc();
    flush = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mid();
      check_eq("t7_hold_valid", 32'(out_valid), 1);
      check_eq("t7_hold_in_ready", 32'(in_ready), 0);
      check_eq("t7_hold_rd", 32'(out_rd), 9);
      check_eq("t7_hold_imm", out_imm, 9);
      check_eq("t7_hold_pc", out_pc, 32'h101c);
      next_cyc();
      flush = 1'b0;
    end
    out_ready = 1'b1;
    mid();
    check_eq("t7_release_valid", 32'(out_valid), 1);
    check_eq("t7_release_in_ready", 32'(in_ready), 1);
    next_cyc();
    in_valid = 1'b0;
    mid();
    check_eq("t7_lui_protect", 32'(protect), 1);
    check_eq("t7_lui_protectw", 32'(protectw), 10);
    next_cyc();
    mid();
    check_eq("t7_lui_valid", 32'(out_valid), 1);
    check_eq("t7_lui_imm", out_imm, 32'h12345000);
    check_eq("t7_lui_rd", 32'(out_rd), 10);
    check_eq("t7_lui_pc", out_pc, 32'h1020);

    // Unknown opcode issues as a NOP
    next_cyc();
    offer(32'hffffffff, 32'h1024);
    mid();
    next_cyc();
    in_valid = 1'b0;
    mid();
    check_eq("t8_nop_reada", 32'(reada), 0);
    check_eq("t8_nop_readb", 32'(readb), 0);
    check_eq("t8_nop_protect", 32'(protect), 0);
    next_cyc();
    mid();
    check_eq("t8_nop_valid", 32'(out_valid), 1);
    check_eq("t8_nop_rd_we", 32'(out_rd_we), 0);
    check_eq("t8_nop_imm", out_imm, 0);

    // jal x1,-4: J-type immediate
    next_cyc();
    offer(32'hffdff0ef, 32'h1028);
    mid();
    next_cyc();
    in_valid = 1'b0;
    out_ready = 1'b0;
    mid();
    check_eq("t9_jal_protectw", 32'(protectw), 1);
    next_cyc();
    mid();
    check_eq("t9_jal_imm", out_imm, 32'hfffffffc);
    check_eq("t9_jal_rd", 32'(out_rd), 1);

    // Reset while a packet waits in SEND
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t10_rst_valid", 32'(out_valid), 0);
    check_eq("t10_rst_in_ready", 32'(in_ready), 1);
    check_eq("t10_rst_mask", dut.r_pend_mask, 0);
    check_eq("t10_rst_imm", out_imm, 0);
    check_eq("t10_rst_rd", 32'(out_rd), 0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
